comparator_nb_seq: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Scans the operands MSB-first, CHUNK bits per clock, and stops at the first differing chunk (early termination).
- Supports unsigned and two's-complement modes.
- Keeps the team's F1/F2/F3 result encoding (equal/less/greater) and adds a start/busy/done handshake, so it drops into sequenced datapaths in place of the combinational 2-bit comparators.

---
 rtl/comparator_nb_seq.sv | 95 +++++++++
 tb/tb_comparator_nb_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_nb_seq.sv
// Multi-cycle MSB-first magnitude comparator. It scans CHUNK bits per clock and stops
// at the first differing chunk. Results use the F1/F2/F3 (eq/lt/gt) encoding.
module comparator_nb_seq #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             F1,
   output logic             F2,
   output logic             F3
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx;
   logic [BW-1:0]    base;
   logic [CHUNK-1:0] ca, cb;
   logic             accept;

   // Index 0 is the most significant chunk.
   always_comb begin
      base = BW'((NCHUNK - 1 - int'(idx)) * CHUNK);
      ca   = a_q[base +: CHUNK];
      cb   = b_q[base +: CHUNK];
   end

   assign accept = start && (state == IDLE || state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         F1    <= 1'b0;
         F2    <= 1'b0;
         F3    <= 1'b0;
      end else if (accept) begin
         // Flipping the sign bit maps two's-complement order onto unsigned order.
         a_q   <= A ^ (signed_mode ? MSB : '0);
         b_q   <= B ^ (signed_mode ? MSB : '0);
         idx   <= '0;
         busy  <= 1'b1;
         done  <= 1'b0;
         F1    <= 1'b0;
         F2    <= 1'b0;
         F3    <= 1'b0;
         state <= BUSY;
      end else begin
         case (state)
            BUSY: begin
               if (ca != cb) begin
                  F3    <= (ca > cb);
                  F2    <= !(ca > cb);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (idx == IW'(NCHUNK - 1)) begin
                  F1    <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparator_nb_seq.sv
// Scoreboard bench for comparator_nb_seq at three geometries (8/2, 16/4, 4/4).
// Stimulus pushes expected {F1,F2,F3, latency}, and per-instance monitors pop on done.
module tb_comparator_nb_seq;

   typedef struct {
      logic [2:0] f;
      int         lat;
   } exp_t;

   localparam logic [2:0] EQ = 3'b100;
   localparam logic [2:0] LT = 3'b010;
   localparam logic [2:0] GT = 3'b001;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_s [3];
   logic        sm_s    [3];
   logic [15:0] a_s     [3];
   logic [15:0] b_s     [3];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   task automatic chk(string nm, int got, int expv);
      n_cmp++;
      if (got != expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, expv);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int W = (g == 1) ? 16 : ((g == 0) ? 8 : 4);
      localparam int C = (g == 0) ? 2 : 4;
      logic busy, done, f1, f2, f3;
      exp_t q[$];
      int   cnt = 0;
      logic [2:0] last = 3'b000;

      comparator_nb_seq #(.WIDTH(W), .CHUNK(C)) dut (
         .clk(clk), .rst(rst), .start(start_s[g]), .signed_mode(sm_s[g]),
         .A(a_s[g][W-1:0]), .B(b_s[g][W-1:0]),
         .busy(busy), .done(done), .F1(f1), .F2(f2), .F3(f3)
      );

      always @(negedge clk) begin
         exp_t e;
         if (rst) begin
            cnt  = 0;
            last = 3'b000;
         end else if (done) begin
            if (q.size() == 0) begin
               chk($sformatf("u%0d_unexpected_done", g), 1, 0);
            end else begin
               e = q.pop_front();
               chk($sformatf("u%0d_flags", g), int'({f1, f2, f3}), int'(e.f));
               chk($sformatf("u%0d_latency", g), cnt, e.lat);
            end
            chk($sformatf("u%0d_busy_at_done", g), int'(busy), 0);
            last = {f1, f2, f3};
            cnt  = 0;
         end else if (busy) begin
            cnt++;
            chk($sformatf("u%0d_flags_while_busy", g), int'({f1, f2, f3}), 0);
         end else begin
            chk($sformatf("u%0d_flags_hold", g), int'({f1, f2, f3}), int'(last));
         end
      end
   end

   task automatic push(int g, exp_t e);
      case (g)
         0: u[0].q.push_back(e);
         1: u[1].q.push_back(e);
         default: u[2].q.push_back(e);
      endcase
   endtask

   function automatic int qsize(int g);
      case (g)
         0: return u[0].q.size();
         1: return u[1].q.size();
         default: return u[2].q.size();
      endcase
   endfunction

   task automatic drain(int g);
      int t = 0;
      while (qsize(g) != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (qsize(g) != 0) begin
         chk($sformatf("u%0d_timeout", g), qsize(g), 0);
         case (g)
            0: u[0].q.delete();
            1: u[1].q.delete();
            default: u[2].q.delete();
         endcase
      end
      @(posedge clk);
   endtask

   task automatic issue(int g, logic [15:0] a, logic [15:0] b, bit sm, logic [2:0] f, int lat);
      exp_t e;
      e.f = f;
      e.lat = lat;
      @(posedge clk); #2;
      a_s[g] = a; b_s[g] = b; sm_s[g] = sm; start_s[g] = 1'b1;
      push(g, e);
      @(posedge clk); #2;
      start_s[g] = 1'b0;
      drain(g);
   endtask

   function automatic exp_t ref_exp(int w, int c, logic [15:0] a, logic [15:0] b, bit sm);
      exp_t e;
      int ia, ib, p;
      logic [15:0] x;
      ia = int'(a);
      ib = int'(b);
      if (sm && a[w-1]) ia -= (1 << w);
      if (sm && b[w-1]) ib -= (1 << w);
      e.f = (ia == ib) ? EQ : ((ia < ib) ? LT : GT);
      x = a ^ b;
      p = -1;
      for (int k = 0; k < w; k++) if (x[k]) p = k;
      e.lat = (p < 0) ? w / c : (w - 1 - p) / c + 1;
      return e;
   endfunction

   task automatic check_all_zero(string tag);
      chk({tag, "_u0"}, int'({u[0].busy, u[0].done, u[0].f1, u[0].f2, u[0].f3}), 0);
      chk({tag, "_u1"}, int'({u[1].busy, u[1].done, u[1].f1, u[1].f2, u[1].f3}), 0);
      chk({tag, "_u2"}, int'({u[2].busy, u[2].done, u[2].f1, u[2].f2, u[2].f3}), 0);
   endtask

   initial begin
      exp_t e;
      int t;
      logic [15:0] ra, rb, mask;
      bit rs;
      int w;
      for (int g = 0; g < 3; g++) begin
         start_s[g] = 1'b0; sm_s[g] = 1'b0; a_s[g] = '0; b_s[g] = '0;
      end
      #1 rst = 1'b1;
      #1 check_all_zero("reset");
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Directed, WIDTH=8 CHUNK=2
      issue(0, 16'hC3, 16'h43, 0, GT, 1);
      repeat (3) @(posedge clk);
      issue(0, 16'h12, 16'h13, 0, LT, 4);
      issue(0, 16'h5A, 16'h5A, 0, EQ, 4);
      issue(0, 16'h80, 16'h7F, 1, LT, 1);
      issue(0, 16'h80, 16'h7F, 0, GT, 1);
      issue(0, 16'hFF, 16'hFE, 1, GT, 4);

      // A second start during BUSY is ignored and A is not re-latched.
      @(posedge clk); #2;
      a_s[0] = 16'h01; b_s[0] = 16'h01; sm_s[0] = 0; start_s[0] = 1'b1;
      e.f = EQ; e.lat = 4; push(0, e);
      @(posedge clk); #2;
      a_s[0] = 16'hFF;
      @(posedge clk); #2;
      start_s[0] = 1'b0;
      drain(0);

      // Back-to-back: start held through the done cycle.
      @(posedge clk); #2;
      a_s[0] = 16'h30; b_s[0] = 16'h20; start_s[0] = 1'b1;
      e.f = GT; e.lat = 2; push(0, e);
      e.f = LT; e.lat = 3; push(0, e);
      @(posedge clk); #2;
      a_s[0] = 16'h04; b_s[0] = 16'h08;
      t = 0;
      while (!u[0].done && t < 20) begin
         @(posedge clk); #2;
         t++;
      end
      chk("b2b_done_seen", int'(u[0].done), 1);
      @(posedge clk); #2;
      chk("b2b_busy_no_gap", int'(u[0].busy), 1);
      start_s[0] = 1'b0;
      drain(0);

      // Asynchronous reset in the second busy cycle of an equal compare.
      @(posedge clk); #2;
      a_s[0] = 16'h33; b_s[0] = 16'h33; start_s[0] = 1'b1;
      @(posedge clk); #2;
      start_s[0] = 1'b0;
      @(posedge clk); #2;
      chk("pre_rst_busy", int'(u[0].busy), 1);
      rst = 1'b1;
      #1 check_all_zero("mid_rst");
      @(posedge clk); #2;
      rst = 1'b0;
      issue(0, 16'h00, 16'h01, 0, LT, 4);

      // Parameter sweep: directed corners plus random operands.
      issue(1, 16'h8000, 16'h7FFF, 1, LT, 1);
      issue(1, 16'h1234, 16'h1235, 0, LT, 4);
      issue(1, 16'hABCD, 16'hABCD, 1, EQ, 4);
      issue(2, 16'h8, 16'h7, 1, LT, 1);
      issue(2, 16'h8, 16'h7, 0, GT, 1);
      issue(2, 16'h5, 16'h5, 0, EQ, 1);
      for (int g = 1; g < 3; g++) begin
         w = (g == 1) ? 16 : 4;
         mask = 16'((32'h1 << w) - 1);
         for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom) & mask;
            rb = ($urandom_range(0, 3) == 0) ? ra : (16'($urandom) & mask);
            rs = 1'($urandom_range(0, 1));
            e = ref_exp(w, (g == 1) ? 4 : 4, ra, rb, rs);
            issue(g, ra, rb, rs, e.f, e.lat);
         end
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
